serial_subtractor: RTL and testbench

Bit-serial N-bit two's-complement subtractor for the lab ALU datapath. It is the inverse-operation counterpart to the combinational adder chain. It latches two operands on a start handshake and processes one bit per clock, LSB first, through a single full-adder cell. The cell computes A + ~B + 1, with the carry held in a flip-flop between bits. It reports the difference, borrow and signed overflow after N cycles, trading latency for area in the multi-cycle ALU path.

---
 rtl/serial_subtractor.sv | 171 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit two's-complement subtractor
//
// Computes a - b one bit per clock, LSB first, through a single full-adder
// cell evaluating A + ~B + 1 with the carry held in a flip-flop.
//
// Optional feature macro: SERIAL_SUB_ADDMODE_EN (adds the 'add' port; add=1
// computes a + b and reports the unsigned carry on 'borrow').
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     request, sampled only while ready=1
//   add       (SERIAL_SUB_ADDMODE_EN only) 1 = a + b, 0 = a - b
//   a, b      operands, captured on the accepted start
//   ready     high only in IDLE
//   done      one-cycle pulse when diff/borrow/overflow are updated
//   diff      result modulo 2^N
//   borrow    unsigned borrow (carry out in add mode)
//   overflow  signed overflow
module serial_subtractor #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef SERIAL_SUB_ADDMODE_EN
    input  logic         add,
`endif
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sa_q, sa_d;
    logic [N-1:0]   sb_q, sb_d;
    logic           c_q, c_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           borrow_q, borrow_d;
    logic           ovf_q, ovf_d;
`ifdef SERIAL_SUB_ADDMODE_EN
    logic           add_q, add_d;
`endif

    logic accept;
    logic last_bit;
    logic s_bit;
    logic cout;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_bit = (cnt_q == LAST);

    // Single full-adder cell on the current LSBs.
    assign s_bit = sa_q[0] ^ sb_q[0] ^ c_q;
    assign cout  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_DONE);
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

    // Datapath next-state. The minuend register doubles as the result shift
    // register: each sum bit enters at the MSB as the consumed LSB leaves, so
    // after N steps it holds the full result.
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
`ifdef SERIAL_SUB_ADDMODE_EN
        add_d    = add_q;
`endif
        if (accept) begin
            sa_d  = a;
            cnt_d = '0;
`ifdef SERIAL_SUB_ADDMODE_EN
            add_d = add;
            sb_d  = add ? b : ~b;
            c_d   = ~add;
`else
            sb_d  = ~b;
            c_d   = 1'b1;
`endif
        end else if (state_q == S_RUN) begin
            sa_d = {s_bit, sa_q[N-1:1]};
            sb_d = {1'b0, sb_q[N-1:1]};
            c_d  = cout;
            if (last_bit) begin
                // c_q is the carry into the MSB, cout the carry out of it.
                diff_d = {s_bit, sa_q[N-1:1]};
                ovf_d  = c_q ^ cout;
`ifdef SERIAL_SUB_ADDMODE_EN
                borrow_d = add_q ? cout : ~cout;
`else
                borrow_d = ~cout;
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q     <= '0;
            sb_q     <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SERIAL_SUB_ADDMODE_EN
            add_q    <= 1'b0;
`endif
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
`ifdef SERIAL_SUB_ADDMODE_EN
            add_q    <= add_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef SERIAL_SUB_ADDMODE_EN
    logic         add;
`endif
    logic         ready;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;
    logic         overflow;

    serial_subtractor #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef SERIAL_SUB_ADDMODE_EN
        .add      (add),
`endif
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         dc;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ad);
        exp_t e;
        int   s;
        s    = ad ? (int'(x) + int'(y)) : (int'(x) - int'(y));
        e.d  = s[7:0];
        e.bo = ad ? (s > 255) : (s < 0);
        if (ad) e.ov = (x[7] == y[7]) && (e.d[7] != x[7]);
        else    e.ov = (x[7] != y[7]) && (e.d[7] != x[7]);
        e.dc = 0;
        return e;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        chk("ready_done_excl", {31'd0, ready & done}, 32'd0);
        if (done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: diff=0x%0h with empty scoreboard (cyc=%0d)", diff, cyc);
            end else begin
                e = q.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, e.d});
                chk("borrow", {31'd0, borrow}, {31'd0, e.bo});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                chk("done_cycle", cyc, e.dc);
            end
        end
    end

    task automatic set_add(input logic ad);
`ifdef SERIAL_SUB_ADDMODE_EN
        add = ad;
`else
        if (ad) $display("note: add mode not built");
`endif
    endtask

    task automatic wait_ready();
        int i;
        @(negedge clk);
        for (i = 0; i < 200 && !ready; i++) @(negedge clk);
        if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    // Issue one operation; returns after the accepting edge (+1).
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic ad,
                         input bit push, output int acc);
        exp_t e;
        wait_ready();
        a = x;
        b = y;
        set_add(ad);
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            e    = model(x, y, ad);
            e.dc = acc + N;
            q.push_back(e);
        end
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        set_add(1'($urandom));
    endtask

    initial begin
        int   k;
        exp_t e;
        logic ad;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        set_add(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with explicit latency checks on the first.
        issue(8'h05, 8'h03, 1'b0, 1'b1, k);
        chk("run_ready_low", {31'd0, ready}, 32'd0);
        repeat (N) @(posedge clk);
        #1;
        chk("done_at_N1", {31'd0, done}, 32'd1);
        chk("ready_low_at_done", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_at_N2", {31'd0, ready}, 32'd1);

        issue(8'h03, 8'h05, 1'b0, 1'b1, k);
        issue(8'h80, 8'h01, 1'b0, 1'b1, k);
        issue(8'h7F, 8'hFF, 1'b0, 1'b1, k);

        // start during RUN must be ignored (no extra done).
        issue(8'h5A, 8'h33, 1'b0, 1'b1, k);
        repeat (3) @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset in cycle 4 of RUN discards the operation.
        issue(8'h44, 8'h11, 1'b0, 1'b0, k);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_diff", {24'd0, diff}, 32'd0);
        chk("midrst_borrow", {31'd0, borrow}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 4) @(negedge clk);
        issue(8'h10, 8'h10, 1'b0, 1'b1, k);

        // rst and start together: rst wins.
        wait_ready();
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h22;
        b     = 8'h01;
        @(posedge clk);
        #1;
        chk("rst_start_idle", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (N + 4) @(negedge clk);

        // Back-to-back with start held high.
        wait_ready();
        a = 8'h9C;
        b = 8'h27;
        set_add(1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        k    = cyc;
        e    = model(8'h9C, 8'h27, 1'b0);
        e.dc = k + N;
        q.push_back(e);
        a = 8'h12;
        b = 8'hE0;
        repeat (N + 2) @(posedge clk);
        #1;
        e    = model(8'h12, 8'hE0, 1'b0);
        e.dc = k + N + 2 + N;
        q.push_back(e);
        start = 1'b0;

`ifdef SERIAL_SUB_ADDMODE_EN
        issue(8'hFF, 8'h01, 1'b1, 1'b1, k);
        issue(8'h7F, 8'h01, 1'b1, 1'b1, k);
`endif

        // Randomised operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_SUB_ADDMODE_EN
            ad = 1'($urandom);
`else
            ad = 1'b0;
`endif
            issue(8'($urandom), 8'($urandom), ad, 1'b1, k);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
